// File: rtl/hvac_zone_ctrl.sv
// hvac_zone_ctrl: NUM_ZONES independent HVAC zone sequencers.
// Each zone runs a Moore FSM that gates heating, cooling and fan outputs.
// A shared per-zone counter enforces minimum run time in HEAT/COOL and times
// the fan overrun in FAN_OUT.
//
// state   | code | meaning
// --------+------+------------------------------------------------------------
// OFF     | 0    | zone disabled, all outputs low
// IDLE    | 1    | zone on, waiting for heat/cool demand (fan if fan-only mode)
// HEAT    | 2    | heating, held for at least MIN_RUN_CYC cycles
// COOL    | 3    | cooling, held for at least MIN_RUN_CYC cycles
// FAN_OUT | 4    | fan overrun for FAN_OVR_CYC cycles after heat/cool stops
module hvac_zone_ctrl #(
  parameter int NUM_ZONES   = 4,
  parameter int TEMP_W      = 8,
  parameter int HYST        = 2,
  parameter int MIN_RUN_CYC = 16,
  parameter int FAN_OVR_CYC = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fault,
  input  logic [NUM_ZONES-1:0]        on_req,
  input  logic [NUM_ZONES-1:0]        off_req,
  input  logic [2*NUM_ZONES-1:0]      mode,
  input  logic [TEMP_W*NUM_ZONES-1:0] temp,
  input  logic [TEMP_W*NUM_ZONES-1:0] setpt,
  output logic [NUM_ZONES-1:0]        heat_en,
  output logic [NUM_ZONES-1:0]        cool_en,
  output logic [NUM_ZONES-1:0]        fan_en,
  output logic [NUM_ZONES-1:0]        active,
  output logic [3*NUM_ZONES-1:0]      zone_state
);

  localparam int CNT_MAX = (MIN_RUN_CYC > FAN_OVR_CYC) ? MIN_RUN_CYC : FAN_OVR_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // HEAT/COOL count up from 0; the exit edge is the one where the count
  // would reach MIN_RUN_CYC, so the output stays high exactly MIN_RUN_CYC cycles
  localparam logic [CW-1:0] RUN_MAX  = CW'(MIN_RUN_CYC);
  localparam logic [CW-1:0] RUN_LAST = CW'(MIN_RUN_CYC - 1);
  localparam logic [CW-1:0] FAN_LOAD = CW'(FAN_OVR_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [TEMP_W:0] HYST_X = (TEMP_W + 1)'(HYST);

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_HEAT = 3'd2;
  localparam logic [2:0] S_COOL = 3'd3;
  localparam logic [2:0] S_FAN  = 3'd4;

  for (genvar z = 0; z < NUM_ZONES; z++) begin : zone_g
    logic [2:0]      state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            off_pend, off_pend_nxt;
    logic [1:0]      zmode;
    logic [TEMP_W:0] t_x, s_x;
    logic            heat_ok, cool_ok, heat_dmd, cool_dmd, run_done;

    // Demand compare at TEMP_W+1 bits so adding the band can never wrap
    always_comb begin
      zmode    = mode[2*z +: 2];
      t_x      = {1'b0, temp[z*TEMP_W +: TEMP_W]};
      s_x      = {1'b0, setpt[z*TEMP_W +: TEMP_W]};
      heat_ok  = (zmode == 2'b00) || (zmode == 2'b01);
      cool_ok  = (zmode == 2'b00) || (zmode == 2'b10);
      heat_dmd = heat_ok && ((t_x + HYST_X) < s_x);
      cool_dmd = cool_ok && (t_x > (s_x + HYST_X));
      run_done = (cnt >= RUN_LAST);
    end

    // Next-state, counter and pending-off logic; fault overrides everything
    always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      off_pend_nxt = off_pend;
      case (state)
        S_OFF: begin
          if (on_req[z] && !off_req[z]) state_nxt = S_IDLE;
        end
        S_IDLE: begin
          if (off_req[z]) begin
            state_nxt = S_OFF;
          end else if (heat_dmd) begin
            state_nxt = S_HEAT;
            cnt_nxt   = CNT_ZERO;
          end else if (cool_dmd) begin
            state_nxt = S_COOL;
            cnt_nxt   = CNT_ZERO;
          end
        end
        S_HEAT: begin
          if (off_req[z]) off_pend_nxt = 1'b1;
          if (run_done && ((t_x >= s_x) || !heat_ok || off_pend)) begin
            state_nxt = S_FAN;
            cnt_nxt   = FAN_LOAD;
          end else if (cnt != RUN_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_COOL: begin
          if (off_req[z]) off_pend_nxt = 1'b1;
          if (run_done && ((t_x <= s_x) || !cool_ok || off_pend)) begin
            state_nxt = S_FAN;
            cnt_nxt   = FAN_LOAD;
          end else if (cnt != RUN_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_FAN: begin
          if (off_req[z]) off_pend_nxt = 1'b1;
          // a late off_req on the final overrun cycle still lands in OFF
          if (cnt == CNT_ZERO) begin
            state_nxt = (off_pend || off_req[z]) ? S_OFF : S_IDLE;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: state_nxt = S_OFF;
      endcase
      if (state_nxt == S_OFF) begin
        cnt_nxt      = CNT_ZERO;
        off_pend_nxt = 1'b0;
      end
      if (fault) begin
        state_nxt    = S_OFF;
        cnt_nxt      = CNT_ZERO;
        off_pend_nxt = 1'b0;
      end
    end

    // Zone state registers, asynchronously cleared by reset
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= S_OFF;
        cnt      <= CNT_ZERO;
        off_pend <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        off_pend <= off_pend_nxt;
      end
    end

    // Outputs decoded from registered state (fan-only uses the live mode)
    always_comb begin
      heat_en[z]          = (state == S_HEAT);
      cool_en[z]          = (state == S_COOL);
      fan_en[z]           = (state == S_HEAT) || (state == S_COOL) || (state == S_FAN) ||
                            ((state == S_IDLE) && (zmode == 2'b11));
      active[z]           = (state != S_OFF);
      zone_state[3*z +: 3] = state;
    end
  end

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Directed bench for hvac_zone_ctrl with two zones, MIN_RUN_CYC=8, FAN_OVR_CYC=4.
module tb_hvac_zone_ctrl;

  logic        clk;
  logic        reset;
  logic        fault;
  logic [1:0]  on_req;
  logic [1:0]  off_req;
  logic [3:0]  mode;
  logic [15:0] temp;
  logic [15:0] setpt;
  logic [1:0]  heat_en;
  logic [1:0]  cool_en;
  logic [1:0]  fan_en;
  logic [1:0]  active;
  logic [5:0]  zone_state;

  int n_cmp = 0;
  int n_err = 0;

  hvac_zone_ctrl #(
    .NUM_ZONES(2), .TEMP_W(8), .HYST(2), .MIN_RUN_CYC(8), .FAN_OVR_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .fault(fault), .on_req(on_req), .off_req(off_req),
    .mode(mode), .temp(temp), .setpt(setpt), .heat_en(heat_en), .cool_en(cool_en),
    .fan_en(fan_en), .active(active), .zone_state(zone_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; fault = 1'b0; on_req = 2'b00; off_req = 2'b00;
    mode = 4'h0; temp = 16'h0; setpt = 16'h0;

    // reset state
    #2;
    chk("rst_state", 32'(zone_state), 32'h0);
    chk("rst_outs", 32'({heat_en, cool_en, fan_en, active}), 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_rst_off", 32'(zone_state), 32'h0);

    // heat cycle: exactly 8 HEAT cycles, 4 FAN_OUT cycles, back to IDLE
    mode[1:0] = 2'b01; temp[7:0] = 8'd18; setpt[7:0] = 8'd22; on_req = 2'b01;
    tick();
    on_req = 2'b00;
    chk("t1_idle", 32'(zone_state[2:0]), 32'd1);
    chk("t1_active", 32'(active[0]), 32'd1);
    tick();
    chk("t1_heat", 32'(zone_state[2:0]), 32'd2);
    temp[7:0] = 8'd23;
    for (int k = 0; k < 8; k++) begin
      chk("t1_heat_en", 32'(heat_en[0]), 32'd1);
      chk("t1_heat_fan", 32'(fan_en[0]), 32'd1);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      chk("t1_fanout_st", 32'(zone_state[2:0]), 32'd4);
      chk("t1_fanout_outs", 32'({heat_en[0], cool_en[0], fan_en[0]}), 32'b001);
      tick();
    end
    chk("t1_back_idle", 32'(zone_state[2:0]), 32'd1);
    chk("t1_idle_fan", 32'(fan_en[0]), 32'd0);

    // off_req mid-heat: min run honoured, overrun, then OFF
    temp[7:0] = 8'd18;
    tick();
    chk("t2_heat", 32'(zone_state[2:0]), 32'd2);
    tick(); tick();
    off_req = 2'b01;
    for (int k = 0; k < 6; k++) begin
      chk("t2_heat_hold", 32'(heat_en[0]), 32'd1);
      tick();
      off_req = 2'b00;
    end
    for (int k = 0; k < 4; k++) begin
      chk("t2_fanout", 32'(zone_state[2:0]), 32'd4);
      tick();
    end
    chk("t2_off", 32'(zone_state[2:0]), 32'd0);
    chk("t2_inactive", 32'(active[0]), 32'd0);

    // zone1 auto mode: inside band stays IDLE, above band cools
    mode[3:2] = 2'b00; setpt[15:8] = 8'd22; temp[15:8] = 8'd24; on_req = 2'b10;
    tick();
    on_req = 2'b00;
    chk("t3_idle", 32'(zone_state[5:3]), 32'd1);
    tick(); tick();
    chk("t3_band_idle", 32'(zone_state[5:3]), 32'd1);
    temp[15:8] = 8'd25;
    tick();
    chk("t3_cool", 32'(zone_state[5:3]), 32'd3);
    chk("t3_cool_en", 32'(cool_en[1]), 32'd1);
    chk("t3_z0_off", 32'(zone_state[2:0]), 32'd0);
    temp[15:8] = 8'd24;

    // zone0 mode flip heat->cool goes through FAN_OUT and IDLE
    mode[1:0] = 2'b01; temp[7:0] = 8'd18; setpt[7:0] = 8'd22; on_req = 2'b01;
    tick();
    on_req = 2'b00;
    chk("t4_idle", 32'(zone_state[2:0]), 32'd1);
    tick();
    mode[1:0] = 2'b10; temp[7:0] = 8'd30;
    for (int i = 0; i < 14; i++) begin
      logic [2:0] exp_st;
      exp_st = (i < 8) ? 3'd2 : (i < 12) ? 3'd4 : (i < 13) ? 3'd1 : 3'd3;
      chk("t4_seq", 32'(zone_state[2:0]), 32'(exp_st));
      chk("t4_no_overlap", 32'(heat_en[0] & cool_en[0]), 32'd0);
      chk("t4_z1_cool", 32'(zone_state[5:3]), 32'd3);
      if (i < 13) tick();
    end

    // fault forces both zones OFF and holds them there
    on_req = 2'b11; fault = 1'b1;
    tick();
    chk("t5_fault_off", 32'(zone_state), 32'h0);
    chk("t5_fault_outs", 32'({heat_en, cool_en, fan_en, active}), 32'h0);
    tick();
    chk("t5_fault_hold", 32'(zone_state), 32'h0);
    fault = 1'b0;
    tick();
    chk("t5_recover", 32'(zone_state), 32'({3'd1, 3'd1}));
    on_req = 2'b00;

    // boundary: extreme values, then async reset mid-FAN_OUT
    mode[1:0] = 2'b00; temp[7:0] = 8'd0; setpt[7:0] = 8'd255;
    tick();
    chk("t6_heat", 32'(zone_state[2:0]), 32'd2);
    chk("t6_no_cool", 32'(cool_en[0]), 32'd0);
    temp[7:0] = 8'd255; setpt[7:0] = 8'd254;
    for (int k = 0; k < 7; k++) tick();
    chk("t6_last_heat", 32'(zone_state[2:0]), 32'd2);
    tick();
    chk("t6_fanout", 32'(zone_state[2:0]), 32'd4);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_async_state", 32'(zone_state), 32'h0);
    chk("t6_async_outs", 32'({heat_en, cool_en, fan_en, active}), 32'h0);
    tick();
    reset = 1'b0;
    on_req = 2'b01;
    tick();
    on_req = 2'b00;
    chk("t6_idle", 32'(zone_state[2:0]), 32'd1);
    tick(); tick();
    chk("t6_no_wrap_cool", 32'(zone_state[2:0]), 32'd1);
    chk("t6_no_wrap_en", 32'(cool_en[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
